// File: rtl/pid_update_scheduler.sv
// Per-period PID update sequencer with rate-limited drive and cadence-based not-pedaling detect.
// Optional REQ watchdog with sticky fault: define PID_WATCHDOG_EN.
module pid_update_scheduler #(
    parameter int unsigned PERIOD      = 1048576,
    parameter int unsigned FAST_SIM    = 0,
    parameter int unsigned PID_LAT     = 3,
    parameter int unsigned RAMP_STEP   = 64,
    parameter int unsigned CAD_TIMEOUT = 25000000,
    parameter int unsigned WDOG_CYC    = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cadence_pulse,
    input  logic        err_vld,
    input  logic [12:0] err_in,
    input  logic [11:0] pid_drv_mag,
    output logic        err_req,
    output logic [12:0] pid_error,
    output logic        pid_tick,
    output logic        pid_not_pedaling,
    output logic [11:0] drv_out,
    output logic        overrun,
    output logic        fault
);

    localparam int unsigned P_EFF = (FAST_SIM != 0) ? 32768 : PERIOD;
    localparam int unsigned PW    = (P_EFF > 1) ? $clog2(P_EFF) : 1;
    localparam int unsigned CW    = $clog2(CAD_TIMEOUT + 1);
    localparam int unsigned LW    = (PID_LAT > 1) ? $clog2(PID_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_TICK,
        S_SETTLE,
        S_APPLY,
        S_FAULT
    } state_t;

    state_t        r_state;
    logic [PW-1:0] r_per;
    logic [CW-1:0] r_cad;
    logic [LW-1:0] r_lat;
    logic          r_np;
    logic          r_err_req;
    logic          r_pid_tick;
    logic [12:0]   r_pid_error;
    logic [11:0]   r_drv;

    logic          w_tick;
    logic [CW-1:0] w_cad_next;
    logic          w_np_next;
    logic [12:0]   w_cur;
    logic [12:0]   w_tgt;
    logic [12:0]   w_diff;
    logic [11:0]   w_drv_apply;

`ifdef PID_WATCHDOG_EN
    localparam int unsigned WW = (WDOG_CYC > 1) ? $clog2(WDOG_CYC) : 1;
    logic [WW-1:0] r_wd;
    logic          r_fault;
    assign fault = r_fault;
`else
    assign fault = 1'b0;
`endif

    always_comb begin
        w_tick = (r_per == PW'(P_EFF - 1));
    end

    // A pulse in the same cycle the timeout would be reached keeps not_pedaling low.
    always_comb begin
        w_cad_next = r_cad;
        if (cadence_pulse)
            w_cad_next = '0;
        else if (r_cad != CW'(CAD_TIMEOUT))
            w_cad_next = r_cad + 1'b1;
        w_np_next = cadence_pulse ? 1'b0 : ((w_cad_next == CW'(CAD_TIMEOUT)) ? 1'b1 : r_np);
    end

    // Rate limit upward moves only; compare in 13 bits so the step never wraps.
    always_comb begin
        w_cur       = {1'b0, r_drv};
        w_tgt       = {1'b0, pid_drv_mag};
        w_diff      = w_tgt - w_cur;
        w_drv_apply = pid_drv_mag;
        if ((w_tgt > w_cur) && (w_diff > 13'(RAMP_STEP)))
            w_drv_apply = 12'(w_cur + 13'(RAMP_STEP));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_per       <= '0;
            r_cad       <= '0;
            r_lat       <= '0;
            r_np        <= 1'b1;
            r_err_req   <= 1'b0;
            r_pid_tick  <= 1'b0;
            r_pid_error <= '0;
            r_drv       <= '0;
`ifdef PID_WATCHDOG_EN
            r_wd        <= '0;
            r_fault     <= 1'b0;
`endif
        end else begin
            r_per      <= w_tick ? '0 : r_per + 1'b1;
            r_cad      <= w_cad_next;
            r_np       <= w_np_next;
            r_pid_tick <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_tick) begin
                        r_state   <= S_REQ;
                        r_err_req <= 1'b1;
`ifdef PID_WATCHDOG_EN
                        r_wd      <= '0;
`endif
                    end
                end
                S_REQ: begin
                    if (err_vld) begin
                        r_pid_error <= err_in;
                        r_err_req   <= 1'b0;
                        r_pid_tick  <= 1'b1;
                        r_state     <= S_TICK;
                    end
`ifdef PID_WATCHDOG_EN
                    else if (r_wd == WW'(WDOG_CYC - 1)) begin
                        r_err_req <= 1'b0;
                        r_fault   <= 1'b1;
                        r_drv     <= '0;
                        r_state   <= S_FAULT;
                    end else begin
                        r_wd <= r_wd + 1'b1;
                    end
`endif
                end
                S_TICK: begin
                    r_lat   <= '0;
                    r_state <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (r_lat == LW'(PID_LAT - 1))
                        r_state <= S_APPLY;
                    else
                        r_lat <= r_lat + 1'b1;
                end
                S_APPLY: begin
                    r_state <= S_IDLE;
                end
                S_FAULT: begin
                    r_err_req <= 1'b0;
                    r_drv     <= '0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
            if (w_np_next)
                r_drv <= '0;
            else if (r_state == S_APPLY)
                r_drv <= w_drv_apply;
        end
    end

    assign err_req          = r_err_req;
    assign pid_error        = r_pid_error;
    assign pid_tick         = r_pid_tick;
    assign pid_not_pedaling = r_np;
    assign drv_out          = r_drv;
    assign overrun          = w_tick & (r_state != S_IDLE);

endmodule

// File: tb/tb_pid_update_scheduler.sv
// Self-checking bench for pid_update_scheduler: vector table, ramp sequence, cadence timeout,
// reset mid-update, overrun and (with PID_WATCHDOG_EN) the REQ watchdog.
module tb_pid_update_scheduler;

    localparam int unsigned PER  = 64;
    localparam int unsigned LAT  = 3;
    localparam int unsigned STEP = 64;
    localparam int unsigned CAD  = 200;
    localparam int unsigned WD   = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cadence_pulse = 1'b0;
    logic        err_vld = 1'b0;
    logic [12:0] err_in = '0;
    logic [11:0] pid_drv_mag = '0;
    logic        err_req;
    logic [12:0] pid_error;
    logic        pid_tick;
    logic        pid_not_pedaling;
    logic [11:0] drv_out;
    logic        overrun;
    logic        fault;

    always #5 clk = ~clk;

    pid_update_scheduler #(
        .PERIOD     (PER),
        .FAST_SIM   (0),
        .PID_LAT    (LAT),
        .RAMP_STEP  (STEP),
        .CAD_TIMEOUT(CAD),
        .WDOG_CYC   (WD)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .cadence_pulse   (cadence_pulse),
        .err_vld         (err_vld),
        .err_in          (err_in),
        .pid_drv_mag     (pid_drv_mag),
        .err_req         (err_req),
        .pid_error       (pid_error),
        .pid_tick        (pid_tick),
        .pid_not_pedaling(pid_not_pedaling),
        .drv_out         (drv_out),
        .overrun         (overrun),
        .fault           (fault)
    );

    typedef struct {
        logic [12:0] err;
        logic [11:0] mag;
        int unsigned wt;
        logic [11:0] exp_drv;
    } vec_t;

    typedef struct {
        logic [12:0] err;
        logic [11:0] drv;
    } exp_t;

    exp_t        sb[$];
    vec_t        tbl[7];
    int          n_cmp = 0;
    int          n_fail = 0;
    int unsigned cyc = 0;
    bit          cad_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // All waiting goes through here so cadence_pulse has a single driver.
    task automatic step();
        @(negedge clk);
        cyc++;
        cadence_pulse = cad_en && (cyc % 50 == 0);
    endtask

    function automatic logic [11:0] ramp_model(input logic [11:0] d, input logic [11:0] t);
        if (t <= d) return t;
        if (int'(t) - int'(d) > int'(STEP)) return d + 12'(STEP);
        return t;
    endfunction

    task automatic wait_req(input string nm);
        int unsigned k = 0;
        while (err_req !== 1'b1 && k < PER + 20) begin
            step();
            k++;
        end
        chk({nm, "_req"}, {31'd0, err_req}, 32'd1);
    endtask

    task automatic do_update(input logic [12:0] e, input logic [11:0] m, input int unsigned wt,
                             input logic [11:0] ed, input string nm);
        exp_t ex;
        wait_req(nm);
        if (err_req !== 1'b1) return;
        for (int unsigned i = 0; i < wt; i++) step();
        err_in      = e;
        err_vld     = 1'b1;
        pid_drv_mag = m;
        sb.push_back('{e, ed});
        step();
        err_vld = 1'b0;
        err_in  = 13'($urandom);
        chk({nm, "_tick"}, {31'd0, pid_tick}, 32'd1);
        ex = sb.pop_front();
        chk({nm, "_err"}, {19'd0, pid_error}, {19'd0, ex.err});
        step();
        chk({nm, "_tick_off"}, {31'd0, pid_tick}, 32'd0);
        repeat (LAT + 1) step();
        chk({nm, "_drv"}, {20'd0, drv_out}, {20'd0, ex.drv});
        chk({nm, "_err_hold"}, {19'd0, pid_error}, {19'd0, ex.err});
    endtask

    task automatic wait_pedal(input string nm);
        int unsigned k = 0;
        while (pid_not_pedaling !== 1'b0 && k < 150) begin
            step();
            k++;
        end
        chk({nm, "_np"}, {31'd0, pid_not_pedaling}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [11:0] d;
        int          n_ovr;
        int          n_drop;
        bit          saw_tick;
        bit          saw_drv;

        tbl[0] = '{13'h0100, 12'h040, 2, 12'h040};
        tbl[1] = '{13'h1F00, 12'h100, 0, 12'h080};
        tbl[2] = '{13'h0FFF, 12'h070, 1, 12'h070};
        tbl[3] = '{13'h1000, 12'h0B0, 3, 12'h0B0};
        tbl[4] = '{13'h0001, 12'h0B1, 0, 12'h0B1};
        tbl[5] = '{13'h0000, 12'h0B1, 0, 12'h0B1};
        tbl[6] = '{13'h1FFF, 12'h000, 2, 12'h000};

        step();
        step();
        chk("rst_err_req", {31'd0, err_req}, 32'd0);
        chk("rst_pid_error", {19'd0, pid_error}, 32'd0);
        chk("rst_pid_tick", {31'd0, pid_tick}, 32'd0);
        chk("rst_np", {31'd0, pid_not_pedaling}, 32'd1);
        chk("rst_drv", {20'd0, drv_out}, 32'd0);
        chk("rst_overrun", {31'd0, overrun}, 32'd0);
        chk("rst_fault", {31'd0, fault}, 32'd0);
        rst    = 1'b0;
        cad_en = 1'b1;
        wait_pedal("start");

        for (int i = 0; i < 7; i++)
            do_update(tbl[i].err, tbl[i].mag, tbl[i].wt, tbl[i].exp_drv, $sformatf("vec%0d", i));

        d = drv_out;
        for (int i = 0; i < 64; i++) begin
            d = ramp_model(d, 12'hFFF);
            do_update(13'(i), 12'hFFF, 0, d, $sformatf("ramp%0d", i));
        end
        chk("ramp_top", {20'd0, drv_out}, 32'h0FFF);
        do_update(13'h0222, 12'h010, 1, 12'h010, "ramp_down");
        chk("fault_clear", {31'd0, fault}, 32'd0);

        // Reset during SETTLE: outputs clear at once, no APPLY follows.
        wait_req("settle");
        err_in      = 13'h0ABC;
        err_vld     = 1'b1;
        pid_drv_mag = 12'h800;
        step();
        err_vld = 1'b0;
        chk("settle_tick", {31'd0, pid_tick}, 32'd1);
        step();
        step();
        rst = 1'b1;
        #1;
        chk("arst_drv", {20'd0, drv_out}, 32'd0);
        chk("arst_np", {31'd0, pid_not_pedaling}, 32'd1);
        chk("arst_err", {19'd0, pid_error}, 32'd0);
        chk("arst_req", {31'd0, err_req}, 32'd0);
        chk("arst_tick", {31'd0, pid_tick}, 32'd0);
        step();
        step();
        rst      = 1'b0;
        saw_tick = 1'b0;
        saw_drv  = 1'b0;
        for (int i = 0; i < int'(PER) - 4; i++) begin
            step();
            if (pid_tick) saw_tick = 1'b1;
            if (drv_out != 12'h000) saw_drv = 1'b1;
        end
        chk("arst_no_tick", {31'd0, saw_tick}, 32'd0);
        chk("arst_no_apply", {31'd0, saw_drv}, 32'd0);

        // Cadence timeout.
        wait_pedal("cad");
        do_update(13'h0123, 12'h040, 1, 12'h040, "cad_pre");
        cad_en = 1'b0;
        step();
        cadence_pulse = 1'b1;
        step();
        chk("cad_pulse_np", {31'd0, pid_not_pedaling}, 32'd0);
        repeat (CAD - 1) step();
        chk("cad_before_np", {31'd0, pid_not_pedaling}, 32'd0);
`ifndef PID_WATCHDOG_EN
        chk("cad_before_drv", {20'd0, drv_out}, 32'h040);
`endif
        step();
        chk("cad_timeout_np", {31'd0, pid_not_pedaling}, 32'd1);
        chk("cad_timeout_drv", {20'd0, drv_out}, 32'd0);
        cadence_pulse = 1'b1;
        step();
        chk("cad_resume_np", {31'd0, pid_not_pedaling}, 32'd0);
        chk("cad_resume_drv", {20'd0, drv_out}, 32'd0);
        cad_en = 1'b1;

`ifndef PID_WATCHDOG_EN
        wait_req("ovr");
        n_ovr  = 0;
        n_drop = 0;
        for (int i = 0; i < int'(PER); i++) begin
            step();
            if (overrun) n_ovr++;
            if (!err_req) n_drop++;
        end
        chk("ovr_count", 32'(n_ovr), 32'd1);
        chk("ovr_stays_req", 32'(n_drop), 32'd0);
        chk("nowd_fault", {31'd0, fault}, 32'd0);
`else
        rst = 1'b1;
        step();
        rst = 1'b0;
        wait_req("wd");
        n_ovr = 0;
        while (fault !== 1'b1 && n_ovr < int'(WD) + 10) begin
            step();
            n_ovr++;
        end
        chk("wd_latency", 32'(n_ovr), 32'(WD));
        chk("wd_drv", {20'd0, drv_out}, 32'd0);
        chk("wd_req", {31'd0, err_req}, 32'd0);
        repeat (PER) step();
        chk("wd_sticky", {31'd0, fault}, 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
